mig_app_arbiter: RTL and testbench
==================================

Name: mig_app_arbiter

Overview:
- Two-requester round-robin arbiter sharing one MIG-style app interface (DRAM MIG or the DPRAM wrapper that emulates it).
- Sequences the command and write-data handshakes independently.
- Tracks outstanding reads in an in-order tag FIFO and routes returned read data to the requester that issued the read.
- Sits between the KV lookup/update engines and the memory controller.

Parameters:
ADDR_WIDTH, 12, app address width
DWIDTH, 128, data width; mask is DWIDTH/8
TAG_DEPTH_BITS, 3, log2 of maximum outstanding reads (tag FIFO depth)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
rq0_req / rq1_req  in  1  request valid, held until ack
rq0_we / rq1_we  in  1  1 = write, 0 = read
rq0_addr / rq1_addr  in  ADDR_WIDTH  address
rq0_wdata / rq1_wdata  in  DWIDTH  write data
rq0_wmask / rq1_wmask  in  DWIDTH/8  write mask (1 = byte masked)
rq0_ack / rq1_ack  out  1  one-cycle pulse: request fully accepted
rq_rd_data  out  DWIDTH  shared read-return bus
rq0_rd_valid / rq1_rd_valid  out  1  read data belongs to this requester
err_underflow  out  1  sticky: read data returned with no outstanding tag
init_calib_complete  in  1  memory ready
app_addr  out  ADDR_WIDTH  to controller
app_cmd  out  3  000 = write, 001 = read
app_en  out  1  command valid
app_wdf_data  out  DWIDTH  write data
app_wdf_mask  out  DWIDTH/8  write mask
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  equals app_wdf_wren (single-beat)
app_rdy  in  1  command accepted
app_wdf_rdy  in  1  write data accepted
app_rd_data  in  DWIDTH  read data
app_rd_data_valid  in  1  read data valid
app_rd_data_end  in  1  ignored (single-beat)

Behaviour:
- Reset (async, sys_rst_n low):
  - All outputs 0, state IDLE, rr_ptr = 0 (requester 0 favoured first), tag FIFO empty, err_underflow = 0.
  - Reset mid-operation discards the in-flight command and all tags; there is no recovery.
- Eligibility: rqN is eligible = rqN_req && init_calib_complete && (rqN_we || !tag_full).
- FSM IDLE:
  - If no requester is eligible, stay in IDLE.
  - If one is eligible, grant it. If both are eligible, grant the rr_ptr side.
  - On grant: register addr/cmd/wdata/mask into the app outputs, set cmd_done = 0, set wdf_done = !we, set rr_ptr = the other requester, go to ISSUE.
  - Latency: req sampled in cycle N gives app_en = 1 in cycle N+1.
- FSM ISSUE:
  - app_en = !cmd_done. app_wdf_wren = app_wdf_end = !wdf_done.
  - cmd_done sets on app_en && app_rdy. wdf_done sets on app_wdf_wren && app_wdf_rdy. The two may complete in either order or in the same cycle.
  - Read: tag (granted requester ID) is pushed in the cycle app_rdy accepts the command.
  - rqN_ack is combinational. It is high in the cycle where (cmd_done || app_rdy) && (wdf_done || app_wdf_rdy). The FSM returns to IDLE next cycle.
  - Throughput: at most one request per 2 cycles.
- Requester rule: req seen high in the cycle after ack is a new request.
- Read return:
  - On app_rd_data_valid, pop the tag. rq_rd_data = app_rd_data, and rq{tag}_rd_valid = 1, both combinational (0 cycle latency).
  - Push and pop in the same cycle are legal. The count is unchanged and tag order is preserved.
  - app_rd_data_valid with the FIFO empty: no rd_valid is asserted and err_underflow sets (sticky until reset).
- Tag FIFO full: reads from both requesters are blocked and writes still win arbitration. A blocked read does not advance rr_ptr.
- Calibration: init_calib_complete low blocks new grants only. An ISSUE already in progress completes.

Decomposition:
- Shared package (mig_app_pkg): CMD_WRITE = 3'b000, CMD_READ = 3'b001, FSM state encodings IDLE/ISSUE.
- Sub-module: the tag FIFO as an instance of the existing fallthrough_small_fifo, WIDTH = 1, MAX_DEPTH_BITS = TAG_DEPTH_BITS. Its reset is driven by !sys_rst_n.

Test Plan:
- Single read: rq0 read addr 0x010, app_rdy = 1. Expect app_en for 1 cycle at N+1 with app_cmd = 001 and rq0_ack in the same cycle. Return data 0xA5 gives rq0_rd_valid = 1 and rq_rd_data = 0xA5, with rq1_rd_valid = 0.
- Write with split handshake: rq1 write addr 0x020, app_rdy = 1, app_wdf_rdy held low for 3 cycles. Expect app_en to drop after 1 cycle, app_wdf_wren held 4 cycles, and rq1_ack only in the cycle app_wdf_rdy rises.
- Contention: rq0 and rq1 both issue continuous reads from reset. Expect grants alternating 0,1,0,1, and return data routed in issue order with 0xA, 0xB, 0xC, 0xD delivered to rq0, rq1, rq0, rq1.
- Tag full: TAG_DEPTH_BITS = 3, issue 8 reads with no returns. A 9th read is not granted while a concurrent rq1 write is granted. One return then unblocks the read.
- Underflow: pulse app_rd_data_valid with no outstanding reads. Expect err_underflow = 1 held, and rq0_rd_valid = rq1_rd_valid = 0.
- Reset mid-ISSUE: assert sys_rst_n = 0 while app_en = 1. Expect all outputs 0 immediately and tag count 0. After release, a new rq0 request is granted first.

Source files
------------

// File: rtl/mig_app_pkg.sv
// Purpose : shared command codes and FSM encoding for the MIG app-port arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Purpose : small first-word-fallthrough FIFO; head entry is visible on dout while !empty.
// Latency : write to dout valid 1 cycle; read pops combinationally-visible head at the clock.
// Backpressure: writes are dropped when full unless a read frees a slot in the same cycle;
//               reads when empty are ignored.
// Ports   : clk, reset (async active-high), din/wr_en, rd_en, dout, full, empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 1,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE = MAX_DEPTH_BITS'(1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE = (MAX_DEPTH_BITS + 1)'(1);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      do_wr, do_rd;

  assign empty = (count_q == '0);
  // count never exceeds DEPTH, so its top bit alone marks full
  assign full  = count_q[MAX_DEPTH_BITS];
  assign dout  = mem_q[rd_ptr_q];

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd) count_d = count_q + CNT_ONE;
    else if (do_rd && !do_wr) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage carries no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mig_app_arbiter.sv
// Purpose : round-robin arbiter of two requesters onto one MIG-style app port, with
//           in-order read-tag tracking to route returned read data.
// Latency : req -> app_en 1 cycle; ack combinational on final handshake; read return 0 cycles.
// Backpressure: app_rdy / app_wdf_rdy stall the ISSUE state; reads stall while the tag FIFO
//               is full; nothing is issued until init_calib_complete.
// Ports   : rq0_* / rq1_* requester side (req held until ack), rq_rd_data + rqN_rd_valid
//           read return, err_underflow sticky error, app_* controller side.
module mig_app_arbiter
  import mig_app_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DWIDTH         = 128,
  parameter int TAG_DEPTH_BITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  rq0_req,
  input  logic                  rq0_we,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DWIDTH-1:0]     rq0_wdata,
  input  logic [DWIDTH/8-1:0]   rq0_wmask,
  output logic                  rq0_ack,
  input  logic                  rq1_req,
  input  logic                  rq1_we,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DWIDTH-1:0]     rq1_wdata,
  input  logic [DWIDTH/8-1:0]   rq1_wmask,
  output logic                  rq1_ack,
  output logic [DWIDTH-1:0]     rq_rd_data,
  output logic                  rq0_rd_valid,
  output logic                  rq1_rd_valid,
  output logic                  err_underflow,
  input  logic                  init_calib_complete,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  output logic [DWIDTH-1:0]     app_wdf_data,
  output logic [DWIDTH/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic [DWIDTH-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end
);

  state_t                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  grant_id_q, grant_id_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  wdf_done_q, wdf_done_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [DWIDTH-1:0]     wdf_data_q, wdf_data_d;
  logic [DWIDTH/8-1:0]   wdf_mask_q, wdf_mask_d;
  logic                  err_underflow_q, err_underflow_d;

  logic                  elig0, elig1, grant_vld, grant_sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0]     sel_wdata;
  logic [DWIDTH/8-1:0]   sel_wmask;
  logic                  issue_done;
  logic                  tag_push, tag_full, tag_empty, tag_dout;
  logic                  unused_rd_end;

  // single-beat transfers: the end marker carries no information
  assign unused_rd_end = app_rd_data_end;

  // a read needs a free tag slot; writes never touch the tag FIFO
  assign elig0     = rq0_req && init_calib_complete && (rq0_we || !tag_full);
  assign elig1     = rq1_req && init_calib_complete && (rq1_we || !tag_full);
  assign grant_vld = elig0 || elig1;
  assign grant_sel = (elig0 && elig1) ? rr_ptr_q : elig1;

  assign sel_we    = grant_sel ? rq1_we    : rq0_we;
  assign sel_addr  = grant_sel ? rq1_addr  : rq0_addr;
  assign sel_wdata = grant_sel ? rq1_wdata : rq0_wdata;
  assign sel_wmask = grant_sel ? rq1_wmask : rq0_wmask;

  // both handshakes either already done or completing this cycle
  assign issue_done = (state_q == ST_ISSUE) &&
                      (cmd_done_q || app_rdy) && (wdf_done_q || app_wdf_rdy);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_vld)  state_d = ST_ISSUE;
      ST_ISSUE: if (issue_done) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    rq0_ack      = 1'b0;
    rq1_ack      = 1'b0;
    if (state_q == ST_ISSUE) begin
      app_en       = !cmd_done_q;
      app_wdf_wren = !wdf_done_q;
      rq0_ack      = issue_done && !grant_id_q;
      rq1_ack      = issue_done &&  grant_id_q;
    end
  end

  assign app_wdf_end = app_wdf_wren;

  // ---------------- datapath next-state ----------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cmd_done_d = cmd_done_q;
    wdf_done_d = wdf_done_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    wdf_data_d = wdf_data_q;
    wdf_mask_d = wdf_mask_q;
    if (state_q == ST_IDLE) begin
      if (grant_vld) begin
        grant_id_d = grant_sel;
        rr_ptr_d   = !grant_sel;
        cmd_done_d = 1'b0;
        // a read has no data phase, so its data handshake starts out complete
        wdf_done_d = !sel_we;
        app_addr_d = sel_addr;
        app_cmd_d  = sel_we ? CMD_WRITE : CMD_READ;
        wdf_data_d = sel_wdata;
        wdf_mask_d = sel_wmask;
      end
    end else begin
      if (app_en && app_rdy)            cmd_done_d = 1'b1;
      if (app_wdf_wren && app_wdf_rdy)  wdf_done_d = 1'b1;
    end
  end

  assign err_underflow_d = err_underflow_q || (app_rd_data_valid && tag_empty);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q        <= 1'b0;
      grant_id_q      <= 1'b0;
      cmd_done_q      <= 1'b0;
      wdf_done_q      <= 1'b0;
      app_addr_q      <= '0;
      app_cmd_q       <= '0;
      wdf_data_q      <= '0;
      wdf_mask_q      <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      cmd_done_q      <= cmd_done_d;
      wdf_done_q      <= wdf_done_d;
      app_addr_q      <= app_addr_d;
      app_cmd_q       <= app_cmd_d;
      wdf_data_q      <= wdf_data_d;
      wdf_mask_q      <= wdf_mask_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign app_addr      = app_addr_q;
  assign app_cmd       = app_cmd_q;
  assign app_wdf_data  = wdf_data_q;
  assign app_wdf_mask  = wdf_mask_q;
  assign err_underflow = err_underflow_q;

  // ---------------- read tag tracking ----------------
  // the tag is the requester ID, pushed when the controller takes the read command
  assign tag_push = app_en && app_rdy && (app_cmd_q == CMD_READ);

  fallthrough_small_fifo #(
    .WIDTH          (1),
    .MAX_DEPTH_BITS (TAG_DEPTH_BITS)
  ) u_tag_fifo (
    .clk   (sys_clk),
    .reset (!sys_rst_n),
    .din   (grant_id_q),
    .wr_en (tag_push),
    .rd_en (app_rd_data_valid),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // returned data is forwarded only when a tag names its owner
  assign rq_rd_data   = app_rd_data_valid ? app_rd_data : '0;
  assign rq0_rd_valid = app_rd_data_valid && !tag_empty && !tag_dout;
  assign rq1_rd_valid = app_rd_data_valid && !tag_empty &&  tag_dout;

endmodule

// File: tb/tb_mig_app_arbiter.sv
module tb_mig_app_arbiter;
  import mig_app_pkg::*;

  localparam int AW = 12;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          rq0_req, rq0_we, rq0_ack, rq1_req, rq1_we, rq1_ack;
  logic [AW-1:0] rq0_addr, rq1_addr, app_addr;
  logic [DW-1:0] rq0_wdata, rq1_wdata, rq_rd_data, app_wdf_data, app_rd_data;
  logic [MW-1:0] rq0_wmask, rq1_wmask, app_wdf_mask;
  logic          rq0_rd_valid, rq1_rd_valid, err_underflow, init_calib_complete;
  logic [2:0]    app_cmd;
  logic          app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy;
  logic          app_rd_data_valid, app_rd_data_end;

  mig_app_arbiter #(.ADDR_WIDTH(AW), .DWIDTH(DW), .TAG_DEPTH_BITS(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_wmask(rq0_wmask), .rq0_ack(rq0_ack),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_wmask(rq1_wmask), .rq1_ack(rq1_ack),
    .rq_rd_data(rq_rd_data), .rq0_rd_valid(rq0_rd_valid), .rq1_rd_valid(rq1_rd_valid),
    .err_underflow(err_underflow), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [MW-1:0] wmask; } req_t;
  typedef struct { logic [AW-1:0] addr; logic [2:0] cmd; } cmd_exp_t;
  typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wdf_exp_t;
  typedef struct { logic v0; logic v1; logic [DW-1:0] data; } rd_exp_t;

  req_t     q0[$], q1[$];
  cmd_exp_t exp_cmd[$];
  wdf_exp_t exp_wdf[$];
  int       exp_ack[$];
  rd_exp_t  exp_rd[$];

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected DUT output at cycle %0d", name, cyc);
  endtask

  // ---------------- requester agents: hold req until ack, next request after ack ----
  initial begin : agent0
    rq0_req = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_wmask = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (q0.size() > 0) begin
        rq0_req = 1'b1; rq0_we = q0[0].we; rq0_addr = q0[0].addr;
        rq0_wdata = q0[0].wdata; rq0_wmask = q0[0].wmask;
      end else rq0_req = 1'b0;
      @(negedge sys_clk);
      if (rq0_req && rq0_ack && sys_rst_n && q0.size() > 0) void'(q0.pop_front());
    end
  end

  initial begin : agent1
    rq1_req = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_wmask = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (q1.size() > 0) begin
        rq1_req = 1'b1; rq1_we = q1[0].we; rq1_addr = q1[0].addr;
        rq1_wdata = q1[0].wdata; rq1_wmask = q1[0].wmask;
      end else rq1_req = 1'b0;
      @(negedge sys_clk);
      if (rq1_req && rq1_ack && sys_rst_n && q1.size() > 0) void'(q1.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  cmd_exp_t m_cmd;
  wdf_exp_t m_wdf;
  rd_exp_t  m_rd;
  int       m_id;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (app_en && app_rdy) begin
        if (exp_cmd.size() == 0) fail_event("cmd_unexpected");
        else begin
          m_cmd = exp_cmd.pop_front();
          check("cmd_addr", app_addr, m_cmd.addr);
          check("cmd_op", app_cmd, m_cmd.cmd);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_wdf.size() == 0) fail_event("wdf_unexpected");
        else begin
          m_wdf = exp_wdf.pop_front();
          check("wdf_data", app_wdf_data, m_wdf.data);
          check("wdf_mask", app_wdf_mask, m_wdf.mask);
          check("wdf_end", app_wdf_end, 1'b1);
        end
      end
      if (rq0_ack || rq1_ack) begin
        if (exp_ack.size() == 0) fail_event("ack_unexpected");
        else begin
          m_id = exp_ack.pop_front();
          check("ack_rq0", rq0_ack, (m_id == 0));
          check("ack_rq1", rq1_ack, (m_id == 1));
        end
      end
      if (app_rd_data_valid) begin
        if (exp_rd.size() == 0) fail_event("rd_unexpected");
        else begin
          m_rd = exp_rd.pop_front();
          check("rd_valid0", rq0_rd_valid, m_rd.v0);
          check("rd_valid1", rq1_rd_valid, m_rd.v1);
          if (m_rd.v0 || m_rd.v1) check("rd_data", rq_rd_data, m_rd.data);
        end
      end else if (rq0_rd_valid || rq1_rd_valid) fail_event("rd_spurious");
    end
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_app_en"}, app_en, 1'b0);
    check({tag, "_wren"}, {app_wdf_wren, app_wdf_end}, 2'b00);
    check({tag, "_addr_cmd"}, {app_addr, app_cmd}, '0);
    check({tag, "_wdf_dm"}, {app_wdf_data, app_wdf_mask}, '0);
    check({tag, "_acks"}, {rq0_ack, rq1_ack}, 2'b00);
    check({tag, "_rdv"}, {rq0_rd_valid, rq1_rd_valid}, 2'b00);
    check({tag, "_rd_data"}, rq_rd_data, '0);
    check({tag, "_err"}, err_underflow, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_ack.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_drain"}, exp_ack.size() + exp_cmd.size(), 0);
  endtask

  task automatic wait_app_en(input string name);
    int n = 0;
    while (!app_en && n < 30) begin @(negedge sys_clk); n++; end
    check({name, "_app_en_seen"}, app_en, 1'b1);
  endtask

  task automatic do_return(input logic [DW-1:0] d, input logic v0, input logic v1);
    exp_rd.push_back('{v0, v1, d});
    @(posedge sys_clk); #1;
    app_rd_data_valid = 1'b1; app_rd_data = d;
    @(posedge sys_clk); #1;
    app_rd_data_valid = 1'b0; app_rd_data = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int t_req, n, en_seen;
    logic [DW-1:0] w2, w4;
    w2 = {4{32'hC0DE_0020}};
    w4 = {4{32'h1234_5678}};
    sys_rst_n = 1'b0; init_calib_complete = 1'b1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // T1: single read
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    exp_cmd.push_back('{12'h010, CMD_READ}); exp_ack.push_back(0);
    q0.push_back('{1'b0, 12'h010, '0, '0});
    n = 0;
    while (!rq0_req && n < 20) begin @(negedge sys_clk); n++; end
    t_req = cyc;
    wait_app_en("t1");
    check("t1_latency", cyc - t_req, 1);
    check("t1_ack_with_en", rq0_ack, 1'b1);
    @(negedge sys_clk);
    check("t1_en_one_cycle", app_en, 1'b0);
    repeat (2) @(negedge sys_clk);
    do_return(128'hA5, 1'b1, 1'b0);
    check("t1_rd_drained", exp_rd.size(), 0);

    // T2: write with command accepted first, data held off 3 cycles
    app_wdf_rdy = 1'b0;
    exp_cmd.push_back('{12'h020, CMD_WRITE}); exp_wdf.push_back('{w2, 16'h00F0});
    exp_ack.push_back(1);
    q1.push_back('{1'b1, 12'h020, w2, 16'h00F0});
    wait_app_en("t2");
    check("t2_wren_c0", app_wdf_wren, 1'b1);
    check("t2_noack_c0", rq1_ack, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(negedge sys_clk);
      check("t2_en_dropped", app_en, 1'b0);
      check("t2_wren_held", app_wdf_wren, 1'b1);
      check("t2_noack", rq1_ack, 1'b0);
    end
    @(posedge sys_clk); #1;
    app_wdf_rdy = 1'b1;
    @(negedge sys_clk);
    check("t2_wren_c3", app_wdf_wren, 1'b1);
    check("t2_ack_c3", rq1_ack, 1'b1);
    @(negedge sys_clk);
    check("t2_wren_off", app_wdf_wren, 1'b0);
    wait_drain("t2", 10);

    // T3: contention from reset, grants alternate starting with rq0
    apply_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    q0.push_back('{1'b0, 12'h100, '0, '0}); q0.push_back('{1'b0, 12'h101, '0, '0});
    q1.push_back('{1'b0, 12'h200, '0, '0}); q1.push_back('{1'b0, 12'h201, '0, '0});
    exp_cmd.push_back('{12'h100, CMD_READ}); exp_ack.push_back(0);
    exp_cmd.push_back('{12'h200, CMD_READ}); exp_ack.push_back(1);
    exp_cmd.push_back('{12'h101, CMD_READ}); exp_ack.push_back(0);
    exp_cmd.push_back('{12'h201, CMD_READ}); exp_ack.push_back(1);
    wait_drain("t3", 40);
    do_return(128'hA, 1'b1, 1'b0);
    do_return(128'hB, 1'b0, 1'b1);
    do_return(128'hC, 1'b1, 1'b0);
    do_return(128'hD, 1'b0, 1'b1);
    check("t3_rd_drained", exp_rd.size(), 0);

    // T4: tag FIFO full blocks reads, write still granted
    apply_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q1.push_back('{1'b0, AW'(12'h300 + i), '0, '0});
      exp_cmd.push_back('{AW'(12'h300 + i), CMD_READ}); exp_ack.push_back(1);
    end
    wait_drain("t4_fill", 60);
    q0.push_back('{1'b0, 12'h3F0, '0, '0});
    q1.push_back('{1'b1, 12'h3F1, w4, 16'h0003});
    exp_cmd.push_back('{12'h3F1, CMD_WRITE}); exp_wdf.push_back('{w4, 16'h0003});
    exp_ack.push_back(1);
    wait_drain("t4_write", 20);
    en_seen = 0;
    repeat (6) begin @(negedge sys_clk); if (app_en) en_seen++; end
    check("t4_read_blocked", en_seen, 0);
    exp_cmd.push_back('{12'h3F0, CMD_READ}); exp_ack.push_back(0);
    do_return(128'h1, 1'b0, 1'b1);
    wait_drain("t4_unblock", 20);
    for (int i = 2; i <= 8; i++) do_return(DW'(i), 1'b0, 1'b1);
    do_return(128'h9, 1'b1, 1'b0);
    check("t4_rd_drained", exp_rd.size(), 0);

    // T5: read data with no outstanding tag
    check("t5_err_before", err_underflow, 1'b0);
    do_return(128'h77, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("t5_err_set", err_underflow, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("t5_err_sticky", err_underflow, 1'b1);

    // T6: reset while a command is stuck in ISSUE
    q0.push_back('{1'b0, 12'h400, '0, '0}); q0.push_back('{1'b0, 12'h401, '0, '0});
    exp_cmd.push_back('{12'h400, CMD_READ}); exp_ack.push_back(0);
    exp_cmd.push_back('{12'h401, CMD_READ}); exp_ack.push_back(0);
    wait_drain("t6_pre", 20);
    app_rdy = 1'b0;
    q0.push_back('{1'b0, 12'h455, '0, '0});
    wait_app_en("t6_stuck");
    #2;
    q0.delete();
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("t6_in_reset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1; app_rdy = 1'b1;
    @(negedge sys_clk);
    q0.push_back('{1'b0, 12'h500, '0, '0});
    q1.push_back('{1'b0, 12'h600, '0, '0});
    exp_cmd.push_back('{12'h500, CMD_READ}); exp_ack.push_back(0);
    exp_cmd.push_back('{12'h600, CMD_READ}); exp_ack.push_back(1);
    wait_drain("t6_post", 20);
    do_return(128'hE0, 1'b1, 1'b0);
    do_return(128'hE1, 1'b0, 1'b1);
    do_return(128'hE2, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("t6_tags_cleared", err_underflow, 1'b1);
    check("t6_rd_drained", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
